// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding and constants for the UART transmit stage
package uart_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_tx_stage_if.sv
// uart_tx_stage_if: valid/ready byte stream feeding the UART transmit stage
interface uart_tx_stage_if;
  import uart_tx_pkg::*;
  logic [DATA_BITS-1:0] data;
  logic valid;
  logic ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter, tick marks the last clk of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    if (!rst_n || clear || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_tx_stage.sv
// uart_tx_stage: serialises bytes as 8N1 UART frames on a registered tx pin.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_stage
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  uart_tx_stage_if.slave s,
  output logic tx,
  output logic busy
);
  state_t state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0] idx;
  logic tick;
  assign s.ready = state == IDLE && ena;
  assign busy = state != IDLE;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk,
    .rst_n,
    .clear(state == IDLE),
    .tick
  );
  // tx is loaded one bit ahead at each boundary so the pin comes straight from a flop
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      tx    <= IDLE_LEVEL;
      shreg <= '0;
      idx   <= '0;
    end else
      case (state)
        IDLE:
          if (s.valid && s.ready) begin
            shreg <= s.data;
            state <= START;
            tx    <= ~IDLE_LEVEL;
          end
        START:
          if (tick) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        DATA:
          if (tick) begin
            idx <= idx + 3'd1;
            if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= ^shreg;
`else
              state <= STOP;
              tx    <= IDLE_LEVEL;
`endif
            end else tx <= shreg[idx + 3'd1];
          end
`ifdef UART_TX_PARITY_EN
        PARITY:
          if (tick) begin
            state <= STOP;
            tx    <= IDLE_LEVEL;
          end
`endif
        STOP:
          if (tick) begin
            if (idx == 3'(STOP_BITS - 1)) begin
              state <= IDLE;
              idx   <= '0;
            end else idx <= idx + 3'd1;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_uart_tx_stage.sv
// tb_uart_tx_stage: random/directed stimulus on one- and two-stop-bit DUTs,
// checked cycle by cycle against a frame-level reference model.
module tb_uart_tx_stage;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  typedef struct {
    logic [7:0] d;
    int t0;
  } fr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic tx1, busy1, tx2, busy2;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit armed = 1'b0;
  int free1 = 0;
  int free2 = 0;
  fr_t q1[$];
  fr_t q2[$];
  uart_tx_stage_if b1();
  uart_tx_stage_if b2();
  always #5 clk = ~clk;
  uart_tx_stage #(.CLKS_PER_BIT(C), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .s(b1), .tx(tx1), .busy(busy1)
  );
  uart_tx_stage #(.CLKS_PER_BIT(C), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .s(b2), .tx(tx2), .busy(busy2)
  );
  function automatic int flen(int sb);
    return (1 + 8 + P + sb) * C;
  endfunction
  // level of frame bit b: start, 8 data LSB first, optional even parity, then stop
  function automatic logic ebit(logic [7:0] d, int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (P == 1 && b == 9) return ^d;
    return 1'b1;
  endfunction
  task automatic chk(string nm, int i, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s[%0d] cyc=%0d got=%b expected=%b", nm, i, cyc, got, exp);
    end
  endtask
  task automatic step(logic r, logic e, logic v, logic [7:0] d, int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst_n = r;
      ena = e;
      b1.valid = v;
      b2.valid = v;
      b1.data = d;
      b2.data = d;
    end
  endtask
  // model: a transfer happens when valid and ena and the previous frame has fully ended
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      armed = 1'b1;
      q1.delete();
      q2.delete();
      free1 = cyc;
      free2 = cyc;
    end else if (armed) begin
      if (b1.valid && ena && cyc - 1 >= free1) begin
        q1.push_back('{b1.data, cyc});
        free1 = cyc + flen(1);
      end
      if (b2.valid && ena && cyc - 1 >= free2) begin
        q2.push_back('{b2.data, cyc});
        free2 = cyc + flen(2);
      end
    end
  end
  always @(negedge clk)
    if (armed) begin
      logic a1, a2, e1, e2;
      while (q1.size() > 0 && cyc >= q1[0].t0 + flen(1)) void'(q1.pop_front());
      while (q2.size() > 0 && cyc >= q2[0].t0 + flen(2)) void'(q2.pop_front());
      a1 = q1.size() > 0;
      a2 = q2.size() > 0;
      e1 = a1 ? ebit(q1[0].d, (cyc - q1[0].t0) / C) : 1'b1;
      e2 = a2 ? ebit(q2[0].d, (cyc - q2[0].t0) / C) : 1'b1;
      chk("tx", 1, tx1, e1);
      chk("busy", 1, busy1, a1);
      chk("ready", 1, b1.ready, ena && !a1);
      chk("tx", 2, tx2, e2);
      chk("busy", 2, busy2, a2);
      chk("ready", 2, b2.ready, ena && !a2);
    end
  initial begin
    b1.valid = 1'b0;
    b2.valid = 1'b0;
    b1.data = 8'h00;
    b2.data = 8'h00;
    step(0, 1, 0, 8'h00, 3);
    step(1, 1, 1, 8'hA5, 1);
    step(1, 1, 0, 8'h00, 50);
    step(1, 1, 1, 8'h00, 1);
    step(1, 1, 1, 8'hFF, 60);
    step(1, 1, 1, 8'h07, 1);
    step(1, 1, 0, 8'h00, 50);
    step(1, 1, 1, 8'h5A, 1);
    step(1, 1, 0, 8'h00, 17);
    step(0, 1, 0, 8'h00, 1);
    step(1, 1, 1, 8'hC3, 1);
    step(1, 1, 0, 8'h00, 50);
    step(1, 0, 1, 8'h77, 30);
    step(1, 1, 1, 8'h96, 1);
    step(1, 1, 0, 8'h00, 10);
    step(1, 0, 1, 8'h11, 60);
    step(1, 1, 1, 8'h3C, 1);
    step(1, 1, 0, 8'h00, 50);
    repeat (4000)
      step($urandom_range(0, 399) != 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(1, 6));
    step(1, 1, 0, 8'h00, 60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
